// File: rtl/ai_move_if.sv
// Bus between the Connect Four board logic and the AI move generator.
// master drives the turn request and board snapshot; slave returns the chosen column.
interface ai_move_if #(
    parameter int ROWS = 7,
    parameter int COLS = 7
);
    logic                     start;
    logic                     term;
    logic [2*ROWS*COLS-1:0]   grid;
    logic [3*COLS-1:0]        column_counts;
    logic [COLS-1:0]          opt;
    logic                     move;
    logic                     busy;
    logic                     no_move;

    modport master (
        output start, term, grid, column_counts,
        input  opt, move, busy, no_move
    );

    modport slave (
        input  start, term, grid, column_counts,
        output opt, move, busy, no_move
    );
endinterface

// File: rtl/ai_move.sv
// Connect Four computer opponent: scans for a winning drop, then a blocking drop,
// then falls back to a centre-out column preference.
module ai_move #(
    parameter int ROWS         = 7,
    parameter int COLS         = 7,
    parameter bit ENABLE_BLOCK = 1'b1
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    ai_move_if.slave io_bus
);
    localparam int NB = 2 * ROWS * COLS;
    localparam int CB = 3 * COLS;
    localparam int CI = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [1:0] PL_AI    = 2'b10;
    localparam logic [1:0] PL_HUMAN = 2'b01;

    typedef enum logic [2:0] {StIdle, StWin, StBlock, StPref, StEmit, StDone} state_e;

    state_e          r_state, w_state_d;
    logic [CI-1:0]   r_col, w_col_d;
    logic [NB-1:0]   r_grid, w_grid_d;
    logic [CB-1:0]   r_counts, w_counts_d;
    logic [COLS-1:0] r_full, w_full_d;
    logic [COLS-1:0] r_opt, w_opt_d;
    logic            r_pref_rdy, w_pref_rdy_d;

    logic            w_hit;
    logic            w_last;
    logic [COLS-1:0] w_onehot;
    logic [COLS-1:0] w_full_now;
    logic [COLS-1:0] w_pick;

    function automatic logic cell_match(input logic [NB-1:0] g, input int r, input int c,
                                        input logic [1:0] p);
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
        return g[2*(r*COLS+c) +: 2] == p;
    endfunction

    // Counts runs of p on both sides of the landing cell along each of the four lines.
    function automatic logic col_hits(input logic [NB-1:0] g, input logic [2:0] cnt,
                                      input int c, input logic [1:0] p);
        int   row, run, dr, dc;
        logic fwd, bwd;
        row = int'(cnt);
        if (row >= ROWS) return 1'b0;
        for (int d = 0; d < 4; d++) begin
            dr  = (d == 0) ? 0 : 1;
            dc  = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
            run = 1;
            fwd = 1'b1;
            bwd = 1'b1;
            for (int k = 1; k < 4; k++) begin
                fwd = fwd & cell_match(g, row + k*dr, c + k*dc, p);
                bwd = bwd & cell_match(g, row - k*dr, c - k*dc, p);
                run = run + int'(fwd) + int'(bwd);
            end
            if (run >= 4) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [COLS-1:0] pref_pick(input logic [COLS-1:0] full);
        logic [COLS-1:0] pick;
        logic            found;
        int              c;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            c = (i % 2 == 1) ? COLS/2 - (i+1)/2 : COLS/2 + (i+1)/2;
            if (!found && c >= 0 && c < COLS && !full[c]) begin
                pick[c] = 1'b1;
                found   = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        w_hit    = col_hits(r_grid, r_counts[3*r_col +: 3], int'(r_col),
                            (r_state == StWin) ? PL_AI : PL_HUMAN);
        w_last   = (r_col == CI'(COLS - 1));
        w_onehot = COLS'(1) << r_col;
        w_full_now = '0;
        for (int c = 0; c < COLS; c++) begin
            w_full_now[c] = int'(r_counts[3*c +: 3]) >= ROWS;
        end
        w_pick = pref_pick(r_full);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_col      <= '0;
            r_grid     <= '0;
            r_counts   <= '0;
            r_full     <= '0;
            r_opt      <= '0;
            r_pref_rdy <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_col      <= w_col_d;
            r_grid     <= w_grid_d;
            r_counts   <= w_counts_d;
            r_full     <= w_full_d;
            r_opt      <= w_opt_d;
            r_pref_rdy <= w_pref_rdy_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_col_d      = r_col;
        w_grid_d     = r_grid;
        w_counts_d   = r_counts;
        w_full_d     = r_full;
        w_opt_d      = r_opt;
        w_pref_rdy_d = r_pref_rdy;
        if (io_bus.term && r_state != StIdle) begin
            w_state_d = StIdle;
            w_opt_d   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (io_bus.start && !io_bus.term) begin
                        w_grid_d     = io_bus.grid;
                        w_counts_d   = io_bus.column_counts;
                        w_col_d      = '0;
                        w_opt_d      = '0;
                        w_pref_rdy_d = 1'b0;
                        w_state_d    = StWin;
                    end
                end
                StWin, StBlock: begin
                    if (w_hit) begin
                        w_opt_d   = w_onehot;
                        w_state_d = StEmit;
                    end else if (w_last) begin
                        w_col_d   = '0;
                        w_state_d = (r_state == StWin && ENABLE_BLOCK) ? StBlock : StPref;
                    end else begin
                        w_col_d = r_col + 1'b1;
                    end
                end
                StPref: begin
                    // First PREF cycle registers the full-column mask, second one picks.
                    if (!r_pref_rdy) begin
                        w_full_d     = w_full_now;
                        w_pref_rdy_d = 1'b1;
                    end else if (w_pick != '0) begin
                        w_opt_d   = w_pick;
                        w_state_d = StEmit;
                    end else begin
                        w_opt_d   = '0;
                        w_state_d = StDone;
                    end
                end
                StEmit, StDone: w_state_d = StIdle;
                default:        w_state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        io_bus.opt     = r_opt;
        io_bus.move    = (r_state == StEmit);
        io_bus.no_move = (r_state == StDone);
        io_bus.busy    = (r_state != StIdle);
    end
endmodule

// File: tb/tb_ai_move.sv
// Self-checking bench for ai_move: directed vector table, corner-case sequences and
// random boards checked against a window-scanning reference model.
module tb_ai_move;
    localparam int ROWS = 7;
    localparam int COLS = 7;
    localparam int NB   = 2 * ROWS * COLS;
    localparam int CB   = 3 * COLS;
    localparam int NCYC = 40;

    logic clk;
    logic rst_n;

    ai_move_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    ai_move #(.ROWS(ROWS), .COLS(COLS), .ENABLE_BLOCK(1'b1)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string           name;
        logic [NB-1:0]   grid;
        logic [CB-1:0]   cnt;
        int              kind;  // 1 = move, 2 = no_move
        logic [COLS-1:0] opt;
        int              cyc;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [NB-1:0] put(input logic [NB-1:0] g, input int r, input int c,
                                          input logic [1:0] v);
        g[2*(r*COLS+c) +: 2] = v;
        return g;
    endfunction

    function automatic logic [CB-1:0] mk_cnt(input int h[COLS]);
        logic [CB-1:0] cc;
        cc = '0;
        for (int c = 0; c < COLS; c++) cc[3*c +: 3] = 3'(h[c]);
        return cc;
    endfunction

    // Drop p into column c and look for any complete 4-cell window through the new piece.
    function automatic bit model_hit(input logic [NB-1:0] g, input logic [CB-1:0] cc,
                                     input int c, input int p);
        int b[ROWS][COLS];
        int dr[4];
        int dc[4];
        int h, r0, c0, r, x;
        bit ok;
        dr[0] = 0; dc[0] = 1;
        dr[1] = 1; dc[1] = 0;
        dr[2] = 1; dc[2] = 1;
        dr[3] = 1; dc[3] = -1;
        h = int'(cc[3*c +: 3]);
        if (h >= ROWS) return 1'b0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) b[i][j] = int'(g[2*(i*COLS+j) +: 2]);
        b[h][c] = p;
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 4; s++) begin
                r0 = h - s*dr[d];
                c0 = c - s*dc[d];
                ok = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    r = r0 + k*dr[d];
                    x = c0 + k*dc[d];
                    if (r < 0 || r >= ROWS || x < 0 || x >= COLS) ok = 1'b0;
                    else if (b[r][x] != p) ok = 1'b0;
                end
                if (ok) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model(input logic [NB-1:0] g, input logic [CB-1:0] cc, output int kind,
                         output logic [COLS-1:0] opt, output int cyc);
        int order[COLS];
        order[0] = 3; order[1] = 2; order[2] = 4; order[3] = 1;
        order[4] = 5; order[5] = 0; order[6] = 6;
        for (int c = 0; c < COLS; c++) begin
            if (model_hit(g, cc, c, 2)) begin
                kind = 1; opt = COLS'(1) << c; cyc = c + 1;
                return;
            end
        end
        for (int c = 0; c < COLS; c++) begin
            if (model_hit(g, cc, c, 1)) begin
                kind = 1; opt = COLS'(1) << c; cyc = COLS + c + 1;
                return;
            end
        end
        for (int i = 0; i < COLS; i++) begin
            if (int'(cc[3*order[i] +: 3]) < ROWS) begin
                kind = 1; opt = COLS'(1) << order[i]; cyc = 2*COLS + 2;
                return;
            end
        end
        kind = 2; opt = '0; cyc = 2*COLS + 2;
    endtask

    // Cycle k is sampled at the negedge after clock edge k; start is sampled at edge 0.
    task automatic run_scan(input logic [NB-1:0] g, input logic [CB-1:0] cc, input int term_at,
                            input bit restart, output int first_cyc, output int kind,
                            output logic [COLS-1:0] opt_at, output int n_move,
                            output int n_nomove, output int n_both,
                            output logic [NCYC:0] busy_seen);
        @(negedge clk);
        bus.grid          = g;
        bus.column_counts = cc;
        bus.start         = 1'b1;
        first_cyc = -1; kind = 0; opt_at = '0;
        n_move = 0; n_nomove = 0; n_both = 0; busy_seen = '0;
        @(posedge clk);
        for (int k = 0; k <= NCYC; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            bus.start    = restart && (k == 3 || k == 8);
            bus.term     = (k == term_at);
            busy_seen[k] = bus.busy;
            if (bus.move && bus.no_move) n_both++;
            if (bus.move) n_move++;
            if (bus.no_move) n_nomove++;
            if ((bus.move || bus.no_move) && first_cyc < 0) begin
                first_cyc = k;
                kind      = bus.move ? 1 : 2;
                opt_at    = bus.opt;
            end
        end
        bus.start = 1'b0;
        bus.term  = 1'b0;
    endtask

    initial begin
        logic [NB-1:0]   g;
        logic [CB-1:0]   cc;
        logic [NB-1:0]   g_win;
        logic [CB-1:0]   cc_win;
        int              h[COLS];
        int              fc, kd, nm, nn, nb, ekind, ecyc;
        logic [COLS-1:0] op, eopt;
        logic [NCYC:0]   bs;
        int              v;

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.term  = 1'b0;
        bus.grid  = '0;
        bus.column_counts = '0;
        #3;
        check("reset_busy", bus.busy, 0);
        check("reset_move", bus.move, 0);
        check("reset_no_move", bus.no_move, 0);
        check("reset_opt", bus.opt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        g = '0; h = '{0, 0, 0, 0, 0, 0, 0};
        tbl.push_back('{"empty", g, mk_cnt(h), 1, 7'b0001000, 16});

        g = '0;
        g = put(g, 0, 0, 2'b10); g = put(g, 0, 1, 2'b10); g = put(g, 0, 2, 2'b10);
        g = put(g, 0, 4, 2'b01); g = put(g, 0, 5, 2'b01); g = put(g, 0, 6, 2'b01);
        h = '{1, 1, 1, 0, 1, 1, 1};
        g_win = g; cc_win = mk_cnt(h);
        tbl.push_back('{"win_over_block", g, mk_cnt(h), 1, 7'b0001000, 4});

        g = '0;
        g = put(g, 0, 5, 2'b01); g = put(g, 1, 5, 2'b01); g = put(g, 2, 5, 2'b01);
        h = '{0, 0, 0, 0, 0, 3, 0};
        tbl.push_back('{"block_vertical", g, mk_cnt(h), 1, 7'b0100000, 13});

        g = '0; h = '{0, 0, 7, 7, 7, 0, 0};
        tbl.push_back('{"pref_skip_full", g, mk_cnt(h), 1, 7'b0000010, 16});

        g = '0; h = '{7, 7, 7, 7, 7, 7, 7};
        tbl.push_back('{"all_full", g, mk_cnt(h), 2, 7'b0000000, 16});

        g = '0;
        g = put(g, 0, 0, 2'b10); g = put(g, 1, 1, 2'b10); g = put(g, 2, 2, 2'b10);
        g = put(g, 0, 1, 2'b01); g = put(g, 0, 2, 2'b01); g = put(g, 1, 2, 2'b01);
        g = put(g, 0, 3, 2'b01); g = put(g, 1, 3, 2'b01); g = put(g, 2, 3, 2'b01);
        h = '{1, 2, 3, 3, 0, 0, 0};
        tbl.push_back('{"diag_win", g, mk_cnt(h), 1, 7'b0001000, 4});

        foreach (tbl[i]) begin
            run_scan(tbl[i].grid, tbl[i].cnt, -1, 1'b0, fc, kd, op, nm, nn, nb, bs);
            check({tbl[i].name, "_kind"}, kd, tbl[i].kind);
            check({tbl[i].name, "_cycle"}, fc, tbl[i].cyc);
            check({tbl[i].name, "_opt"}, op, tbl[i].opt);
            check({tbl[i].name, "_one_strobe"}, nm + nn, 1);
            check({tbl[i].name, "_excl"}, nb, 0);
            check({tbl[i].name, "_opt_hold"}, bus.opt, tbl[i].opt);
            if (i == 0) begin
                check("empty_busy_1_16", bs[16:1], 16'hFFFF);
                check("empty_busy_17", bs[17], 0);
            end
        end

        // opt is still held from diag_win; async reset must clear it between edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_opt_held", bus.opt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        bus.grid = '0; bus.column_counts = '0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_block_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_opt", bus.opt, 0);
        check("async_rst_move", bus.move, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_scan(g_win, cc_win, 3, 1'b0, fc, kd, op, nm, nn, nb, bs);
        check("term_vs_hit_moves", nm + nn, 0);
        check("term_vs_hit_busy", bs[4], 0);
        check("term_vs_hit_opt", bus.opt, 0);

        run_scan('0, '0, 5, 1'b0, fc, kd, op, nm, nn, nb, bs);
        check("term_c5_moves", nm + nn, 0);
        check("term_c5_busy", bs[6], 0);

        run_scan('0, '0, -1, 1'b1, fc, kd, op, nm, nn, nb, bs);
        check("restart_moves", nm, 1);
        check("restart_cycle", fc, 16);
        check("restart_opt", op, 7'b0001000);

        @(negedge clk);
        bus.start = 1'b1; bus.term = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.term = 1'b0;
        check("idle_start_with_term", bus.busy, 0);

        for (int t = 0; t < 40; t++) begin
            g = '0;
            for (int i = 0; i < ROWS*COLS; i++) begin
                v = int'($urandom_range(0, 9));
                g[2*i +: 2] = (v < 3) ? 2'b00 : (v < 6) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11;
            end
            cc = '0;
            for (int c = 0; c < COLS; c++) cc[3*c +: 3] = 3'($urandom_range(0, 7));
            model(g, cc, ekind, eopt, ecyc);
            run_scan(g, cc, -1, 1'b0, fc, kd, op, nm, nn, nb, bs);
            check($sformatf("rand%0d_kind", t), kd, ekind);
            check($sformatf("rand%0d_cycle", t), fc, ecyc);
            check($sformatf("rand%0d_opt", t), op, eopt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
